avalon_mm_cmd_master: RTL

Single-outstanding Avalon-MM master that turns a simple valid/ready command port into Avalon read/write transfers toward the register slaves on the PCP bus. It sits directly upstream of the 4-register Avalon slave and drives its 11-bit address, 4-bit byteenable, and 32-bit data interface. It honours waitrequest, captures read data, and aborts any transfer whose waitrequest never releases, reporting that transfer as an error.

---
 rtl/avalon_mm_cmd_master_if.sv | 47 ++++
 rtl/avalon_mm_cmd_master.sv | 109 ++++++++++
 2 files changed

// File: rtl/avalon_mm_cmd_master_if.sv
// Command port and Avalon-MM bus of avalon_mm_cmd_master, grouped in one bundle.
//   cmd_*   : valid/ready command input (cmd_ready driven by the master)
//   rsp_*   : one-cycle response pulse with read data and error flag
//   err_count : saturating count of error responses
//   avm_*   : Avalon-MM master signals toward the register slave
// Modport "master" is the view of avalon_mm_cmd_master. Modport "slave" is the
// view of whatever drives commands and models the Avalon slave.
interface avalon_mm_cmd_master_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_W = DATA_WIDTH / 8;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_address;
  logic [BE_W-1:0]       cmd_byteenable;
  logic [DATA_WIDTH-1:0] cmd_writedata;

  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_readdata;
  logic                  rsp_error;
  logic [7:0]            err_count;

  logic [ADDR_WIDTH-1:0] avm_address;
  logic [BE_W-1:0]       avm_byteenable;
  logic                  avm_read;
  logic                  avm_write;
  logic [DATA_WIDTH-1:0] avm_writedata;
  logic [DATA_WIDTH-1:0] avm_readdata;
  logic                  avm_waitrequest;

  modport master (
    input  cmd_valid, cmd_write, cmd_address, cmd_byteenable, cmd_writedata,
    input  avm_readdata, avm_waitrequest,
    output cmd_ready, rsp_valid, rsp_readdata, rsp_error, err_count,
    output avm_address, avm_byteenable, avm_read, avm_write, avm_writedata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_address, cmd_byteenable, cmd_writedata,
    output avm_readdata, avm_waitrequest,
    input  cmd_ready, rsp_valid, rsp_readdata, rsp_error, err_count,
    input  avm_address, avm_byteenable, avm_read, avm_write, avm_writedata
  );
endinterface

// File: rtl/avalon_mm_cmd_master.sv
// Single-outstanding Avalon-MM master. Accepts one command at a time on a
// valid/ready port, runs it as an Avalon read or write honouring waitrequest,
// and returns a one-cycle response. A transfer whose waitrequest stays high
// for TIMEOUT edges is aborted and answered with an error; a command with no
// byte lanes enabled is answered with an error without touching the bus.
// Ports:
//   iClk    : clock, rising edge
//   nReset  : synchronous, active-low reset
//   bus     : command/response/Avalon bundle (master modport)
// Parameters: ADDR_WIDTH, DATA_WIDTH, TIMEOUT (1..255).
module avalon_mm_cmd_master #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                   iClk,
  input  logic                   nReset,
  avalon_mm_cmd_master_if.master bus
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] wait_cnt;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign bus.cmd_ready = (state == IDLE);

  always_ff @(posedge iClk) begin
    if (!nReset) begin
      state              <= IDLE;
      wait_cnt           <= '0;
      bus.avm_address    <= '0;
      bus.avm_byteenable <= '0;
      bus.avm_read       <= 1'b0;
      bus.avm_write      <= 1'b0;
      bus.avm_writedata  <= '0;
      bus.rsp_valid      <= 1'b0;
      bus.rsp_error      <= 1'b0;
      bus.rsp_readdata   <= '0;
      bus.err_count      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            if (bus.cmd_byteenable != '0) begin
              // Word-align by clearing the two low address bits.
              bus.avm_address    <= bus.cmd_address & ~ADDR_WIDTH'(3);
              bus.avm_byteenable <= bus.cmd_byteenable;
              bus.avm_writedata  <= bus.cmd_writedata;
              bus.avm_read       <= ~bus.cmd_write;
              bus.avm_write      <= bus.cmd_write;
              wait_cnt           <= '0;
              state              <= BUS;
            end else begin
              bus.rsp_valid     <= 1'b1;
              bus.rsp_error     <= 1'b1;
              bus.rsp_readdata  <= '0;
              bus.err_count     <= sat_inc(bus.err_count);
              state             <= RESP;
            end
          end
        end

        BUS: begin
          // Completion is checked first so a release on the last allowed
          // edge still counts as a normal transfer.
          if (!bus.avm_waitrequest) begin
            bus.avm_read     <= 1'b0;
            bus.avm_write    <= 1'b0;
            bus.rsp_valid    <= 1'b1;
            bus.rsp_error    <= 1'b0;
            bus.rsp_readdata <= bus.avm_read ? bus.avm_readdata : '0;
            state            <= RESP;
          end else if (wait_cnt == WAIT_LAST) begin
            bus.avm_read     <= 1'b0;
            bus.avm_write    <= 1'b0;
            bus.rsp_valid    <= 1'b1;
            bus.rsp_error    <= 1'b1;
            bus.rsp_readdata <= '0;
            bus.err_count    <= sat_inc(bus.err_count);
            state            <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        RESP: begin
          bus.rsp_valid    <= 1'b0;
          bus.rsp_error    <= 1'b0;
          bus.rsp_readdata <= '0;
          state            <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
